// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Elastic pipeline-stage register with 2-entry skid buffer and
//            write-back bypass into captured and held operands.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int CTRL_W   = 64,
  parameter int NUM_SRC  = 2,
  parameter int NUM_WB   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [NUM_SRC*ADDR_W-1:0]   in_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]   in_src_data,
  input  logic [NUM_WB-1:0]           wb_en,
  input  logic [NUM_WB*ADDR_W-1:0]    wb_addr,
  input  logic [NUM_WB*DATA_W-1:0]    wb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [NUM_SRC*ADDR_W-1:0]   out_src_addr,
  output logic [NUM_SRC*DATA_W-1:0]   out_src_data,
  output logic                        skid_full
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                      r_state;
  logic                        r_out_valid;
  logic                        r_in_ready;
  logic                        r_skid_full;
  logic [CTRL_W-1:0]           r_main_ctrl;
  logic [NUM_SRC*ADDR_W-1:0]   r_main_addr;
  logic [NUM_SRC*DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]           r_skid_ctrl;
  logic [NUM_SRC*ADDR_W-1:0]   r_skid_addr;
  logic [NUM_SRC*DATA_W-1:0]   r_skid_data;

  logic                        w_in_xfer;
  logic                        w_out_xfer;
  logic [NUM_SRC*DATA_W-1:0]   w_in_byp;
  logic [NUM_SRC*DATA_W-1:0]   w_main_byp;
  logic [NUM_SRC*DATA_W-1:0]   w_skid_byp;

  // Scan from the highest port down so the lowest matching port wins.
  function automatic logic [DATA_W-1:0] f_bypass(input logic [ADDR_W-1:0] addr,
                                                 input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] v;
    v = data;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_en[k] && (wb_addr[k*ADDR_W +: ADDR_W] == addr) &&
          !((ZERO_REG != 0) && (addr == '0))) begin
        v = wb_data[k*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign w_in_byp[i*DATA_W +: DATA_W] =
        f_bypass(in_src_addr[i*ADDR_W +: ADDR_W], in_src_data[i*DATA_W +: DATA_W]);
      assign w_main_byp[i*DATA_W +: DATA_W] =
        f_bypass(r_main_addr[i*ADDR_W +: ADDR_W], r_main_data[i*DATA_W +: DATA_W]);
      assign w_skid_byp[i*DATA_W +: DATA_W] =
        f_bypass(r_skid_addr[i*ADDR_W +: ADDR_W], r_skid_data[i*DATA_W +: DATA_W]);
    end
  endgenerate

  // flush suppresses acceptance; in_ready alone is never combinational on out_ready
  assign w_in_xfer  = in_valid & r_in_ready & ~flush;
  assign w_out_xfer = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_skid_full <= 1'b0;
      r_main_ctrl <= '0;
      r_main_addr <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_addr <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_skid_full <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main_ctrl <= in_ctrl;
            r_main_addr <= in_src_addr;
            r_main_data <= w_in_byp;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_addr <= in_src_addr;
            r_skid_data <= w_in_byp;
            r_main_data <= w_main_byp;
            r_state     <= S_FULL;
            r_skid_full <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (w_in_xfer && w_out_xfer) begin
            r_main_ctrl <= in_ctrl;
            r_main_addr <= in_src_addr;
            r_main_data <= w_in_byp;
          end else if (w_out_xfer) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end else begin
            r_main_data <= w_main_byp;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            // skid entry lands in main with this cycle's write-backs applied
            r_main_ctrl <= r_skid_ctrl;
            r_main_addr <= r_skid_addr;
            r_main_data <= w_skid_byp;
            r_state     <= S_ONE;
            r_skid_full <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_main_data <= w_main_byp;
            r_skid_data <= w_skid_byp;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_skid_full <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign skid_full    = r_skid_full;
  assign out_ctrl     = r_main_ctrl;
  assign out_src_addr = r_main_addr;
  assign out_src_data = r_main_data;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Directed self-checking bench for pipe_stage_skid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_ctrl;
  logic [9:0]  in_src_addr;
  logic [63:0] in_src_data;
  logic [1:0]  wb_en;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_ctrl;
  logic [9:0]  out_src_addr;
  logic [63:0] out_src_data;
  logic        skid_full;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_skid dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_src_addr  (in_src_addr),
    .in_src_data  (in_src_data),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_src_addr (out_src_addr),
    .out_src_data (out_src_data),
    .skid_full    (skid_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0;
    in_src_addr = '0; in_src_data = '0; wb_en = '0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_skid_full", {63'd0, skid_full}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_ctrl",  out_ctrl,           64'd0);
    chk("rst_out_data",  out_src_data,       64'd0);
    rst = 1'b1;
    step();

    // back-to-back, full throughput
    in_valid = 1'b1; in_ctrl = 64'd1; out_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("b2b_ctrl",  out_ctrl, 64'(c));
      chk("b2b_valid", {63'd0, out_valid}, 64'd1);
      chk("b2b_skid",  {63'd0, skid_full}, 64'd0);
      chk("b2b_ready", {63'd0, in_ready},  64'd1);
      if (c < 8) in_ctrl = 64'(c + 1);
      else       in_valid = 1'b0;
    end
    step();
    chk("b2b_drain", {63'd0, out_valid}, 64'd0);

    // stall A,B,C
    in_valid = 1'b1; in_ctrl = 64'hA; out_ready = 1'b0;
    step();
    chk("stall_A", out_ctrl, 64'hA);
    chk("stall_rdy1", {63'd0, in_ready}, 64'd1);
    in_ctrl = 64'hB;
    step();
    chk("stall_A_held", out_ctrl, 64'hA);
    chk("stall_skid", {63'd0, skid_full}, 64'd1);
    chk("stall_rdy0", {63'd0, in_ready}, 64'd0);
    in_ctrl = 64'hC;
    step();
    chk("stall_A_held2", out_ctrl, 64'hA);
    chk("stall_rdy0b", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("rel_B", out_ctrl, 64'hB);
    chk("rel_skid", {63'd0, skid_full}, 64'd0);
    chk("rel_rdy", {63'd0, in_ready}, 64'd1);
    step();
    chk("rel_C", out_ctrl, 64'hC);
    chk("rel_C_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    step();
    chk("rel_empty", {63'd0, out_valid}, 64'd0);

    // capture bypass
    in_valid = 1'b1; in_ctrl = 64'h30;
    in_src_addr = {5'd3, 5'd5}; in_src_data = {32'h22, 32'h11};
    wb_en = 2'b01; wb_addr = {5'd9, 5'd5}; wb_data = {32'hBB, 32'hAA};
    step();
    chk("cap_byp_d0", {32'd0, out_src_data[31:0]},  64'hAA);
    chk("cap_byp_d1", {32'd0, out_src_data[63:32]}, 64'h22);
    in_src_addr = {5'd3, 5'd0}; wb_addr = {5'd9, 5'd0};
    step();
    chk("cap_x0_d0", {32'd0, out_src_data[31:0]}, 64'h11);
    in_valid = 1'b0; wb_en = 2'b00;
    step();
    chk("cap_empty", {63'd0, out_valid}, 64'd0);

    // hold refresh and port priority
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 64'h40;
    in_src_addr = {5'd7, 5'd2}; in_src_data = {32'h77, 32'h20};
    step();
    chk("hold_init_d1", {32'd0, out_src_data[63:32]}, 64'h77);
    in_valid = 1'b0;
    wb_en = 2'b11; wb_addr = {5'd7, 5'd7}; wb_data = {32'h2, 32'h1};
    step();
    chk("hold_prio_d1", {32'd0, out_src_data[63:32]}, 64'h1);
    chk("hold_d0_kept", {32'd0, out_src_data[31:0]},  64'h20);
    wb_en = 2'b10;
    step();
    chk("hold_port1_d1", {32'd0, out_src_data[63:32]}, 64'h2);
    wb_en = 2'b00; out_ready = 1'b1;
    step();
    chk("hold_empty", {63'd0, out_valid}, 64'd0);

    // skid-to-main move picks up same-cycle write-back
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 64'h71;
    in_src_addr = {5'd0, 5'd1}; in_src_data = {32'h0, 32'h10};
    step();
    in_ctrl = 64'h72; in_src_addr = {5'd0, 5'd4}; in_src_data = {32'h0, 32'h40};
    step();
    chk("move_full", {63'd0, skid_full}, 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    wb_en = 2'b01; wb_addr = {5'd0, 5'd4}; wb_data = {32'h0, 32'h44};
    step();
    chk("move_ctrl", out_ctrl, 64'h72);
    chk("move_byp_d0", {32'd0, out_src_data[31:0]}, 64'h44);
    wb_en = 2'b00;
    step();
    chk("move_empty", {63'd0, out_valid}, 64'd0);

    // flush in FULL with in_valid high
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 64'h51;
    step();
    in_ctrl = 64'h52;
    step();
    chk("fl_full", {63'd0, skid_full}, 64'd1);
    in_ctrl = 64'h53; flush = 1'b1;
    step();
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_skid",  {63'd0, skid_full}, 64'd0);
    chk("fl_rdy",   {63'd0, in_ready},  64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_ghost", {63'd0, out_valid}, 64'd0);

    // flush in ONE overrides an acceptable input
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 64'h54;
    step();
    chk("fl1_one", {63'd0, out_valid}, 64'd1);
    in_ctrl = 64'h55; flush = 1'b1;
    step();
    chk("fl1_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl1_no_ghost", {63'd0, out_valid}, 64'd0);

    // async reset mid-stream
    in_valid = 1'b1; in_ctrl = 64'h61;
    step();
    in_ctrl = 64'h62;
    step();
    chk("ar_pre_skid", {63'd0, skid_full}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_skid",  {63'd0, skid_full}, 64'd0);
    chk("ar_rdy",   {63'd0, in_ready},  64'd1);
    chk("ar_ctrl",  out_ctrl,           64'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("ar_post_valid", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
